// File: rtl/pipe_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl_if
// Bundles the hazard/exception requests going into the pipeline sequencer
// and the hold/flush controls coming back out of it.
//   Requests (pipeline -> sequencer):
//     stallreq_id   load-use hazard from decode
//     ex_mc_start   EX begins a multi-cycle op this cycle
//     ex_mc_kind    0 = multiply, 1 = divide
//     excpt_valid   exception taken at MEM this cycle
//     excpt_vector  handler address
//   Controls (sequencer -> pipeline):
//     stall[5:0]    bit0 PC .. bit5 WB hold
//     flush         clear all pipeline registers, load new_pc into PC
//     new_pc        redirect address
//     mc_done       EX multi-cycle result ready this cycle
//     busy          sequencer is not in its idle/run state
// The master modport is the pipeline side; the slave modport is the sequencer.
// ---------------------------------------------------------------------------
interface pipe_stall_ctrl_if;
    logic        stallreq_id;
    logic        ex_mc_start;
    logic        ex_mc_kind;
    logic        excpt_valid;
    logic [31:0] excpt_vector;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_done;
    logic        busy;

    modport master (
        output stallreq_id, ex_mc_start, ex_mc_kind, excpt_valid, excpt_vector,
        input  stall, flush, new_pc, mc_done, busy
    );

    modport slave (
        input  stallreq_id, ex_mc_start, ex_mc_kind, excpt_valid, excpt_vector,
        output stall, flush, new_pc, mc_done, busy
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
// Pipeline sequencer that merges load-use stalls from ID, multi-cycle
// mul/div operations from EX and exceptions from MEM into a 6-bit stall
// vector, a one-cycle flush pulse and a redirect PC. Multi-cycle ops are
// timed here with a down-counter so the EX units never hold their own stall.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   ctrl  pipe_stall_ctrl_if.slave: requests in, stall/flush controls out
// Parameters:
//   MUL_CYCLES  stall cycles for a multiply (0 behaves as 1)
//   DIV_CYCLES  stall cycles for a divide   (0 behaves as 1)
//   CNT_W       counter width, 2**CNT_W must exceed both cycle counts
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stall_ctrl_if.slave ctrl
);

    localparam int MulN = (MUL_CYCLES == 0) ? 1 : MUL_CYCLES;
    localparam int DivN = (DIV_CYCLES == 0) ? 1 : DIV_CYCLES;

    // The counter is loaded with N-1 on the start cycle, because the start
    // cycle itself is already the first of the N stalled cycles.
    localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MulN - 1);
    localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DivN - 1);

    localparam logic [5:0] NO_STALL = 6'b000000;
    localparam logic [5:0] ID_STALL = 6'b000111;
    localparam logic [5:0] EX_STALL = 6'b001111;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_BUSY = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      newPc_q, newPc_d;

    logic [5:0]       stallOut;
    logic             flushOut;
    logic             mcDoneOut;
    logic             busyOut;

    // State register: sequencer state, multi-cycle down-counter and the
    // redirect PC. Reset drops any operation in flight on the spot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            newPc_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            newPc_q <= newPc_d;
        end
    end

    // Next-state logic. Exceptions win over everything: in RUN they beat a
    // simultaneous multi-cycle start, and in MC_BUSY they abort the op and
    // clear the counter. FLUSH is a single cycle that ignores all requests.
    // A start request while already in MC_BUSY cannot legally occur (EX is
    // stalled) and is simply not looked at there.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        newPc_d = newPc_q;
        case (state_q)
            RUN: begin
                if (ctrl.excpt_valid) begin
                    state_d = FLUSH;
                    newPc_d = ctrl.excpt_vector;
                end else if (ctrl.ex_mc_start) begin
                    state_d = MC_BUSY;
                    cnt_d   = ctrl.ex_mc_kind ? DivLoad : MulLoad;
                end
            end
            MC_BUSY: begin
                if (ctrl.excpt_valid) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                    newPc_d = ctrl.excpt_vector;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Output logic. All controls except new_pc are combinational so the
    // stall reaches PC/IF/ID in the same cycle as the request. While rst is
    // high every control is forced low, independent of the inputs. In the
    // last MC_BUSY cycle (counter at zero) EX/MEM is released to capture the
    // result, so only a pending load-use stall can still hold the front end.
    always_comb begin
        stallOut  = NO_STALL;
        flushOut  = 1'b0;
        mcDoneOut = 1'b0;
        busyOut   = 1'b0;
        if (!rst) begin
            busyOut = (state_q != RUN);
            case (state_q)
                RUN: begin
                    if (ctrl.excpt_valid) begin
                        stallOut = NO_STALL;
                    end else if (ctrl.ex_mc_start) begin
                        stallOut = EX_STALL;
                    end else if (ctrl.stallreq_id) begin
                        stallOut = ID_STALL;
                    end
                end
                MC_BUSY: begin
                    if (ctrl.excpt_valid) begin
                        stallOut = NO_STALL;
                    end else if (cnt_q != '0) begin
                        stallOut = EX_STALL;
                    end else begin
                        mcDoneOut = 1'b1;
                        stallOut  = ctrl.stallreq_id ? ID_STALL : NO_STALL;
                    end
                end
                FLUSH: begin
                    flushOut = 1'b1;
                end
                default: begin
                    stallOut = NO_STALL;
                end
            endcase
        end
    end

    assign ctrl.stall   = stallOut;
    assign ctrl.flush   = flushOut;
    assign ctrl.mc_done = mcDoneOut;
    assign ctrl.busy    = busyOut;
    assign ctrl.new_pc  = newPc_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Drives two sequencers from the same request signals: one with the default
// cycle counts (mul 2, div 32) and one with mul 0 (behaves as 1) and div 3.
// A cycle-numbered reference model predicts every output on every falling
// edge; directed sequences add literal expectations for the first instance.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        idIn = 1'b0;
    logic        startIn = 1'b0;
    logic        kindIn = 1'b0;
    logic        excIn = 1'b0;
    logic [31:0] vecIn = 32'h0;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] ID_S = 6'b000111;
    localparam logic [5:0] EX_S = 6'b001111;

    always #5 clk = ~clk;

    pipe_stall_ctrl_if busA();
    pipe_stall_ctrl_if busB();

    assign busA.stallreq_id  = idIn;
    assign busA.ex_mc_start  = startIn;
    assign busA.ex_mc_kind   = kindIn;
    assign busA.excpt_valid  = excIn;
    assign busA.excpt_vector = vecIn;
    assign busB.stallreq_id  = idIn;
    assign busB.ex_mc_start  = startIn;
    assign busB.ex_mc_kind   = kindIn;
    assign busB.excpt_valid  = excIn;
    assign busB.excpt_vector = vecIn;

    pipe_stall_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(32), .CNT_W(6)) dutA (
        .clk  (clk),
        .rst  (rst),
        .ctrl (busA)
    );

    pipe_stall_ctrl #(.MUL_CYCLES(0), .DIV_CYCLES(3), .CNT_W(2)) dutB (
        .clk  (clk),
        .rst  (rst),
        .ctrl (busB)
    );

    // Single comparison helper shared by the model checker and the
    // directed sequences.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: an operation started in cycle s with length n stalls
    // in cycles s .. s+n-1 and completes in cycle s+n; an exception seen in
    // cycle c produces the flush in cycle c+1. Outputs are predicted from
    // these cycle numbers plus the current requests, then compared.
    longint      cyc = 0;
    bit          mcActive[2] = '{0, 0};
    longint      mcStart[2]  = '{0, 0};
    int          mcN[2]      = '{0, 0};
    longint      flushCyc[2] = '{-1, -1};
    logic [31:0] pcNow[2]    = '{32'h0, 32'h0};
    int          nMul[2]     = '{2, 1};
    int          nDiv[2]     = '{32, 3};

    always @(negedge clk) begin
        logic [5:0]  eStall;
        logic        eFlush, eDone, eBusy;
        logic [31:0] ePc, pcNext;
        bit          loadPc;
        logic [5:0]  gStall;
        logic        gFlush, gDone, gBusy;
        logic [31:0] gPc;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            eStall = 6'b0; eFlush = 1'b0; eDone = 1'b0; eBusy = 1'b0;
            loadPc = 1'b0; pcNext = 32'h0;
            if (rst) begin
                mcActive[k] = 1'b0;
                flushCyc[k] = -1;
                pcNow[k]    = 32'h0;
            end else if (cyc == flushCyc[k]) begin
                eFlush = 1'b1;
                eBusy  = 1'b1;
            end else if (mcActive[k]) begin
                eBusy = 1'b1;
                if (excIn) begin
                    loadPc = 1'b1; pcNext = vecIn;
                    flushCyc[k] = cyc + 1;
                    mcActive[k] = 1'b0;
                end else if (cyc - mcStart[k] < longint'(mcN[k])) begin
                    eStall = EX_S;
                end else begin
                    eDone = 1'b1;
                    eStall = idIn ? ID_S : 6'b0;
                    mcActive[k] = 1'b0;
                end
            end else begin
                if (excIn) begin
                    loadPc = 1'b1; pcNext = vecIn;
                    flushCyc[k] = cyc + 1;
                end else if (startIn) begin
                    eStall = EX_S;
                    mcActive[k] = 1'b1;
                    mcStart[k] = cyc;
                    mcN[k] = kindIn ? nDiv[k] : nMul[k];
                end else begin
                    eStall = idIn ? ID_S : 6'b0;
                end
            end
            ePc = pcNow[k];
            if (k == 0) begin
                gStall = busA.stall; gFlush = busA.flush; gDone = busA.mc_done;
                gBusy = busA.busy; gPc = busA.new_pc;
            end else begin
                gStall = busB.stall; gFlush = busB.flush; gDone = busB.mc_done;
                gBusy = busB.busy; gPc = busB.new_pc;
            end
            checkOutput($sformatf("model%0d.stall", k),   32'(gStall), 32'(eStall));
            checkOutput($sformatf("model%0d.flush", k),   32'(gFlush), 32'(eFlush));
            checkOutput($sformatf("model%0d.mc_done", k), 32'(gDone),  32'(eDone));
            checkOutput($sformatf("model%0d.busy", k),    32'(gBusy),  32'(eBusy));
            checkOutput($sformatf("model%0d.new_pc", k),  gPc,         ePc);
            if (loadPc) pcNow[k] = pcNext;
        end
    end

    // Drive one cycle's worth of requests just after the rising edge and
    // wait until the falling edge, where outputs are settled.
    task automatic applyStimulus(input logic id, input logic start, input logic kind,
                                 input logic exc, input logic [31:0] vec);
        @(posedge clk);
        #1;
        idIn = id; startIn = start; kindIn = kind; excIn = exc; vecIn = vec;
        @(negedge clk);
    endtask

    int doneSeen;

    // Directed sequences with hand-computed expectations on instance A,
    // followed by a randomized soak checked by the model.
    initial begin
        // Reset with every request asserted: all controls must stay low.
        idIn = 1'b1; startIn = 1'b1; excIn = 1'b1; vecIn = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("rst.stall",   32'(busA.stall),   32'h0);
        checkOutput("rst.flush",   32'(busA.flush),   32'h0);
        checkOutput("rst.mc_done", 32'(busA.mc_done), 32'h0);
        checkOutput("rst.busy",    32'(busA.busy),    32'h0);
        checkOutput("rst.new_pc",  busA.new_pc,       32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; idIn = 1'b0; startIn = 1'b0; excIn = 1'b0; vecIn = 32'h0;
        @(negedge clk);

        // Load-use stall for one cycle only.
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("loaduse.stall", 32'(busA.stall), 32'(ID_S));
        checkOutput("loaduse.busy",  32'(busA.busy),  32'h0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("loaduse.after", 32'(busA.stall), 32'h0);

        // Multiply: two stall cycles, done in the third.
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("mul.t.stall",  32'(busA.stall), 32'(EX_S));
        checkOutput("mul.t.busy",   32'(busA.busy),  32'h0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mul.t1.stall", 32'(busA.stall), 32'(EX_S));
        checkOutput("mul.t1.busy",  32'(busA.busy),  32'h1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mul.t2.done",  32'(busA.mc_done), 32'h1);
        checkOutput("mul.t2.stall", 32'(busA.stall),   32'h0);
        checkOutput("mul.t2.busy",  32'(busA.busy),    32'h1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mul.t3.busy",  32'(busA.busy),    32'h0);

        // Divide with load-use held throughout: 32 EX stalls then done+ID.
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("div.c1.stall", 32'(busA.stall), 32'(EX_S));
        for (int i = 2; i <= 32; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            checkOutput($sformatf("div.c%0d.stall", i), 32'(busA.stall), 32'(EX_S));
        end
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("div.c33.stall", 32'(busA.stall),   32'(ID_S));
        checkOutput("div.c33.done",  32'(busA.mc_done), 32'h1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("div.c34.busy",  32'(busA.busy),    32'h0);
        checkOutput("div.c34.done",  32'(busA.mc_done), 32'h0);

        // Exception in RUN beats a simultaneous multi-cycle start.
        applyStimulus(0, 1, 0, 1, 32'h0000_0020);
        checkOutput("exc.t.stall",   32'(busA.stall), 32'h0);
        checkOutput("exc.t.flush",   32'(busA.flush), 32'h0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("exc.t1.flush",  32'(busA.flush), 32'h1);
        checkOutput("exc.t1.new_pc", busA.new_pc,     32'h0000_0020);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("exc.t2.flush",  32'(busA.flush), 32'h0);
        checkOutput("exc.t2.busy",   32'(busA.busy),  32'h0);

        // Abort a divide at busy cycle 10.
        applyStimulus(0, 1, 1, 0, 0);
        for (int i = 1; i < 10; i++) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'hBFC0_0380);
        checkOutput("abort.stall", 32'(busA.stall),   32'h0);
        checkOutput("abort.done",  32'(busA.mc_done), 32'h0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("abort.flush",  32'(busA.flush), 32'h1);
        checkOutput("abort.new_pc", busA.new_pc,     32'hBFC0_0380);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("abort.run",    32'(busA.busy),  32'h0);
        // A following multiply must behave normally after the cleared count.
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("abort.mul.done", 32'(busA.mc_done), 32'h1);

        // Async reset between edges at busy cycle 5 of a divide.
        applyStimulus(0, 1, 1, 0, 0);
        for (int i = 1; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("arst.pre.stall", 32'(busA.stall), 32'(EX_S));
        checkOutput("arst.pre.busy",  32'(busA.busy),  32'h1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("arst.stall", 32'(busA.stall), 32'h0);
        checkOutput("arst.busy",  32'(busA.busy),  32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            if (busA.mc_done) doneSeen++;
        end
        checkOutput("arst.noDone", 32'(doneSeen), 32'h0);

        // Randomized soak, including occasional reset pulses.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            rst     = ($urandom_range(0, 199) == 0);
            idIn    = ($urandom_range(0, 2) == 0);
            startIn = ($urandom_range(0, 5) == 0);
            kindIn  = $urandom_range(0, 1) == 1;
            excIn   = ($urandom_range(0, 15) == 0);
            vecIn   = $urandom();
        end
        @(posedge clk);
        #1;
        rst = 1'b0; idIn = 1'b0; startIn = 1'b0; excIn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
